// File: rtl/uart_sipo_rx.sv
// UART receive deserializer: 16x oversampled start detection, 7/8 data bits LSB-first,
// optional odd/even parity and 1/2 stop bits, with a one-cycle done pulse and error flags.
module uart_sipo_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       BaudOut,
  input  logic       rst,
  input  logic       data_in,
  input  logic [1:0] parity_type,
  input  logic       stop_bits,
  input  logic       data_length,
  output logic [7:0] data_parll,
  output logic       rx_active,
  output logic       rx_done,
  output logic       parity_error,
  output logic       stop_error
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t          state_q;
  logic [1:0]      sync_q;
  logic            s_prev_q;
  logic [TW-1:0]   tick_q;
  logic [2:0]      bit_q;
  logic [7:0]      shreg_q;
  logic [1:0]      ptype_q;
  logic            stop2_q;
  logic            len8_q;
  logic            par_flag_q;
  logic            stop_flag_q;
  logic            s;

  assign s = sync_q[1];

  // Returns 1 when data ones plus the parity bit disagree with the selected sense.
  function automatic logic parity_bad(input logic [7:0] sh, input logic len8,
                                      input logic [1:0] ptype, input logic pbit);
    logic ones;
    ones = len8 ? (^sh) : (^sh[7:1]);
    if (ptype == 2'b01) begin
      parity_bad = ~(ones ^ pbit);
    end else begin
      parity_bad = ones ^ pbit;
    end
  endfunction

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge BaudOut) begin
    if (rst) begin
      sync_q   <= 2'b11;
      s_prev_q <= 1'b1;
    end else begin
      sync_q   <= {sync_q[0], data_in};
      s_prev_q <= sync_q[1];
    end
  end

  // Frame FSM; outputs are loaded on the final stop sample so rx_done is high during DONE.
  always_ff @(posedge BaudOut) begin
    if (rst) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      bit_q        <= 3'd0;
      shreg_q      <= 8'h00;
      ptype_q      <= 2'b00;
      stop2_q      <= 1'b0;
      len8_q       <= 1'b0;
      par_flag_q   <= 1'b0;
      stop_flag_q  <= 1'b0;
      data_parll   <= 8'h00;
      rx_active    <= 1'b0;
      rx_done      <= 1'b0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (s_prev_q && !s) begin
            tick_q    <= '0;
            rx_active <= 1'b1;
            state_q   <= START;
          end
        end
        START: begin
          tick_q <= tick_q + TW'(1);
          if (tick_q == TICK_MID) begin
            if (!s) begin
              ptype_q     <= parity_type;
              stop2_q     <= stop_bits;
              len8_q      <= data_length;
              tick_q      <= '0;
              bit_q       <= 3'd0;
              par_flag_q  <= 1'b0;
              stop_flag_q <= 1'b0;
              state_q     <= DATA;
            end else begin
              rx_active <= 1'b0;
              state_q   <= IDLE;
            end
          end
        end
        DATA: begin
          tick_q <= tick_q + TW'(1);
          if (tick_q == TICK_END) begin
            shreg_q <= {s, shreg_q[7:1]};
            if (bit_q == (len8_q ? 3'd7 : 3'd6)) begin
              bit_q   <= 3'd0;
              state_q <= ((ptype_q == 2'b01) || (ptype_q == 2'b10)) ? PARITY : STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end
        end
        PARITY: begin
          tick_q <= tick_q + TW'(1);
          if (tick_q == TICK_END) begin
            par_flag_q <= parity_bad(shreg_q, len8_q, ptype_q, s);
            state_q    <= STOP;
          end
        end
        STOP: begin
          tick_q <= tick_q + TW'(1);
          if (tick_q == TICK_END) begin
            if (stop2_q && (bit_q == 3'd0)) begin
              stop_flag_q <= stop_flag_q | ~s;
              bit_q       <= 3'd1;
            end else begin
              data_parll   <= len8_q ? shreg_q : {1'b0, shreg_q[7:1]};
              parity_error <= par_flag_q;
              stop_error   <= stop_flag_q | ~s;
              rx_done      <= 1'b1;
              state_q      <= DONE;
            end
          end
        end
        DONE: begin
          rx_done   <= 1'b0;
          rx_active <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          rx_done   <= 1'b0;
          rx_active <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_sipo_rx.sv
// Directed self-checking bench for uart_sipo_rx with hand-computed frames and expectations.
module tb_uart_sipo_rx;

  localparam int OS = 16;

  logic       BaudOut;
  logic       rst;
  logic       data_in;
  logic [1:0] parity_type;
  logic       stop_bits;
  logic       data_length;
  logic [7:0] data_parll;
  logic       rx_active;
  logic       rx_done;
  logic       parity_error;
  logic       stop_error;

  int vec;
  int err;
  int cyc;
  int done_cnt;
  int done_cyc;
  int act_cnt;
  int e0;

  uart_sipo_rx #(.OVERSAMPLE(OS)) dut (
    .BaudOut      (BaudOut),
    .rst          (rst),
    .data_in      (data_in),
    .parity_type  (parity_type),
    .stop_bits    (stop_bits),
    .data_length  (data_length),
    .data_parll   (data_parll),
    .rx_active    (rx_active),
    .rx_done      (rx_done),
    .parity_error (parity_error),
    .stop_error   (stop_error)
  );

  initial BaudOut = 1'b0;
  always #5 BaudOut = ~BaudOut;

  always @(posedge BaudOut) cyc <= cyc + 1;

  always @(negedge BaudOut) begin
    if (rx_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (rx_active) act_cnt <= act_cnt + 1;
  end

  // Drives one frame; abort_bit >= 0 asserts rst during that frame bit and returns with rst high.
  task automatic send_frame(input logic [7:0] d, input int nd, input int has_par,
                            input logic pbit, input int nstop, input logic stopv,
                            input int abort_bit);
    logic [15:0] bits;
    int n;
    bits = '1;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < nd; i++) begin bits[n] = d[i]; n++; end
    if (has_par != 0) begin bits[n] = pbit; n++; end
    for (int i = 0; i < nstop; i++) begin bits[n] = stopv; n++; end
    @(posedge BaudOut); #1;
    e0 = cyc + 1;
    for (int i = 0; i < n; i++) begin
      data_in = bits[i];
      if (i == abort_bit) begin
        repeat (8) @(posedge BaudOut);
        #1 rst = 1'b1;
        @(posedge BaudOut);
        @(negedge BaudOut);
        return;
      end
      repeat (OS) @(posedge BaudOut);
      #1;
    end
    data_in = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge BaudOut);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    data_in = 1'b1;
    parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b1;
    repeat (3) @(posedge BaudOut);
    @(negedge BaudOut);
    vec++;
    if ({data_parll, rx_active, rx_done, parity_error, stop_error} !== 12'h000) begin
      err++;
      $display("FAIL reset_outputs: got data=%h act=%b done=%b pe=%b se=%b, want all 0",
               data_parll, rx_active, rx_done, parity_error, stop_error);
    end
    @(posedge BaudOut); #1 rst = 1'b0;
    idle(20);
  endtask

  task automatic test_8n1;
    int b_done, b_act;
    parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b1;
    b_done = done_cnt; b_act = act_cnt;
    send_frame(8'hA5, 8, 0, 1'b0, 1, 1'b1, -1);
    idle(10);
    vec++;
    if (done_cnt - b_done !== 1) begin err++; $display("FAIL 8n1_done_count: got %0d, want 1", done_cnt - b_done); end
    vec++;
    if (done_cyc - e0 !== 154) begin err++; $display("FAIL 8n1_done_latency: got %0d, want 154", done_cyc - e0); end
    vec++;
    if (data_parll !== 8'hA5) begin err++; $display("FAIL 8n1_data: got %h, want a5", data_parll); end
    vec++;
    if ({parity_error, stop_error} !== 2'b00) begin err++; $display("FAIL 8n1_flags: got %b, want 00", {parity_error, stop_error}); end
    vec++;
    if (act_cnt - b_act !== 153) begin err++; $display("FAIL 8n1_active_cycles: got %0d, want 153", act_cnt - b_act); end
  endtask

  task automatic test_7e2;
    parity_type = 2'b10; stop_bits = 1'b1; data_length = 1'b0;
    send_frame(8'h53, 7, 1, 1'b0, 2, 1'b1, -1);
    idle(10);
    vec++;
    if (data_parll !== 8'h53) begin err++; $display("FAIL 7e2_data: got %h, want 53", data_parll); end
    vec++;
    if ({parity_error, stop_error} !== 2'b00) begin err++; $display("FAIL 7e2_flags: got %b, want 00", {parity_error, stop_error}); end
    send_frame(8'h53, 7, 1, 1'b1, 2, 1'b1, -1);
    idle(10);
    vec++;
    if (parity_error !== 1'b1) begin err++; $display("FAIL 7e2_bad_parity: got %b, want 1", parity_error); end
    vec++;
    if (data_parll !== 8'h53) begin err++; $display("FAIL 7e2_bad_parity_data: got %h, want 53", data_parll); end
  endtask

  task automatic test_8o1;
    parity_type = 2'b01; stop_bits = 1'b0; data_length = 1'b1;
    send_frame(8'h0F, 8, 1, 1'b0, 1, 1'b1, -1);
    idle(10);
    vec++;
    if (parity_error !== 1'b1) begin err++; $display("FAIL 8o1_parity_error: got %b, want 1", parity_error); end
    vec++;
    if (data_parll !== 8'h0F) begin err++; $display("FAIL 8o1_data: got %h, want 0f", data_parll); end
    parity_type = 2'b00;
    send_frame(8'h3C, 8, 0, 1'b0, 1, 1'b1, -1);
    idle(10);
    vec++;
    if ({data_parll, parity_error} !== {8'h3C, 1'b0}) begin
      err++; $display("FAIL 8n1_parity_clear: got data=%h pe=%b, want 3c/0", data_parll, parity_error);
    end
  endtask

  task automatic test_glitch;
    int b_done, b_act;
    b_done = done_cnt; b_act = act_cnt;
    @(posedge BaudOut); #1 data_in = 1'b0;
    idle(4);
    data_in = 1'b1;
    idle(40);
    vec++;
    if (act_cnt - b_act <= 0) begin err++; $display("FAIL glitch_start_entered: got %0d active cycles, want >0", act_cnt - b_act); end
    vec++;
    if (done_cnt - b_done !== 0) begin err++; $display("FAIL glitch_no_done: got %0d, want 0", done_cnt - b_done); end
    vec++;
    if (rx_active !== 1'b0) begin err++; $display("FAIL glitch_inactive: got %b, want 0", rx_active); end
    vec++;
    if ({data_parll, parity_error, stop_error} !== {8'h3C, 2'b00}) begin
      err++; $display("FAIL glitch_outputs_held: got %h/%b/%b, want 3c/0/0", data_parll, parity_error, stop_error);
    end
  endtask

  task automatic test_break;
    int b_done;
    parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b1;
    b_done = done_cnt;
    send_frame(8'h00, 8, 0, 1'b0, 1, 1'b0, -1);
    data_in = 1'b0;
    idle(40 * OS);
    vec++;
    if (done_cnt - b_done !== 1) begin err++; $display("FAIL break_done_count: got %0d, want 1", done_cnt - b_done); end
    vec++;
    if ({data_parll, stop_error} !== {8'h00, 1'b1}) begin
      err++; $display("FAIL break_flags: got data=%h se=%b, want 00/1", data_parll, stop_error);
    end
    data_in = 1'b1;
    idle(32);
    vec++;
    if (done_cnt - b_done !== 1) begin err++; $display("FAIL break_no_retrigger: got %0d, want 1", done_cnt - b_done); end
  endtask

  task automatic test_midframe_reset;
    int b_done;
    parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b1;
    b_done = done_cnt;
    send_frame(8'hFF, 8, 0, 1'b0, 1, 1'b1, 4);
    vec++;
    if ({data_parll, rx_active, rx_done, parity_error, stop_error} !== 12'h000) begin
      err++;
      $display("FAIL midreset_outputs: got data=%h act=%b done=%b pe=%b se=%b, want all 0",
               data_parll, rx_active, rx_done, parity_error, stop_error);
    end
    #1 rst = 1'b0;
    data_in = 1'b1;
    idle(5 * OS);
    vec++;
    if (done_cnt - b_done !== 0) begin err++; $display("FAIL midreset_no_done: got %0d, want 0", done_cnt - b_done); end
    send_frame(8'h81, 8, 0, 1'b0, 1, 1'b1, -1);
    idle(10);
    vec++;
    if ({data_parll, done_cnt - b_done} !== {8'h81, 32'd1}) begin
      err++; $display("FAIL midreset_next_frame: got data=%h done=%0d, want 81/1", data_parll, done_cnt - b_done);
    end
  endtask

  task automatic test_back_to_back;
    int b_done;
    parity_type = 2'b00; stop_bits = 1'b0; data_length = 1'b1;
    b_done = done_cnt;
    send_frame(8'h12, 8, 0, 1'b0, 1, 1'b1, -1);
    vec++;
    if (data_parll !== 8'h12) begin err++; $display("FAIL b2b_first: got %h, want 12", data_parll); end
    send_frame(8'hC7, 8, 0, 1'b0, 1, 1'b1, -1);
    idle(10);
    vec++;
    if ({data_parll, done_cnt - b_done} !== {8'hC7, 32'd2}) begin
      err++; $display("FAIL b2b_second: got data=%h done=%0d, want c7/2", data_parll, done_cnt - b_done);
    end
  endtask

  initial begin
    vec = 0; err = 0; cyc = 0; done_cnt = 0; done_cyc = 0; act_cnt = 0; e0 = 0;
    test_reset();
    test_8n1();
    test_7e2();
    test_8o1();
    test_glitch();
    test_break();
    test_midframe_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
